reg_seq: RTL and testbench

Register-file sequencer for the 16-bit datapath. It accepts one register-to-register operation at a time over a valid/ready handshake and sequences the register array. It drives one-hot A/B read selects for the tri-stated selector buses, starts the ALU and waits for its completion under a watchdog, then pulses the one-hot bus-load enable of the destination register. It sits between the instruction decoder and the register array/ALU.

---
 rtl/reg_seq.sv | 104 ++++++++++
 tb/tb_reg_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_seq.sv
// Register-file sequencer: latches one reg-to-reg op, drives one-hot A/B selects, starts the ALU
// under a watchdog, then pulses the destination load enable. Accept-to-done is 2+ cycles.
module reg_seq #(
  parameter int NREG     = 8,
  parameter int IW       = 3,
  parameter int TIMEOUT  = 16,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [IW-1:0]   ra,
  input  logic [IW-1:0]   rb,
  input  logic [IW-1:0]   rd,
  input  logic            wb,
  input  logic            alu_done,
  output logic            alu_start,
  output logic [NREG-1:0] sel_a,
  output logic [NREG-1:0] sel_b,
  output logic [NREG-1:0] en,
  output logic            done,
  output logic            err,
  output logic            busy
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ra_q, ra_d, rb_q, rb_d, rd_q, rd_d;
  logic          wb_q, wb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          wr_allowed;

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rd_d    = rd_q;
    wb_d    = wb_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          ra_d    = ra;
          rb_d    = rb;
          rd_d    = rd;
          wb_d    = wb;
          cnt_d   = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + CW'(1);
        // A completion on the last watchdog cycle still wins over the timeout.
        if (alu_done) begin
          state_d = WRITE;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      wb_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rd_q    <= rd_d;
      wb_q    <= wb_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Outputs are forced low while rst is high, so ready stays 0 through the whole reset window.
  assign wr_allowed  = wb_q && !((ZERO_REG != 0) && (rd_q == '0));
  assign instr_ready = !rst && (state_q == IDLE);
  assign busy        = !rst && (state_q != IDLE);
  assign alu_start   = !rst && (state_q == EXEC) && (cnt_q == '0);
  assign sel_a       = (!rst && state_q == EXEC) ? (NREG'(1) << ra_q) : '0;
  assign sel_b       = (!rst && state_q == EXEC) ? (NREG'(1) << rb_q) : '0;
  assign en          = (!rst && state_q == WRITE && wr_allowed) ? (NREG'(1) << rd_q) : '0;
  assign done        = !rst && (state_q == WRITE);
  assign err         = !rst && err_q;

endmodule

// File: tb/tb_reg_seq.sv
// Scoreboard bench for reg_seq: drivers push expected responses, a negedge monitor checks them.
module tb_reg_seq;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [2:0] ra, rb, rd;
  logic       wb;
  logic       alu_done;

  logic       instr_ready, alu_start, done, err, busy;
  logic [7:0] sel_a, sel_b, en;
  logic       instr_ready_z, alu_start_z, done_z, err_z, busy_z;
  logic [7:0] sel_a_z, sel_b_z, en_z;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] sa;
    logic [7:0] sb;
    logic [7:0] en1;
    logic [7:0] en0;
    int         k;
    bit         to;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  reg_seq #(.NREG(8), .IW(3), .TIMEOUT(TIMEOUT), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .ra(ra), .rb(rb), .rd(rd), .wb(wb), .alu_done(alu_done), .alu_start(alu_start),
    .sel_a(sel_a), .sel_b(sel_b), .en(en), .done(done), .err(err), .busy(busy)
  );

  reg_seq #(.NREG(8), .IW(3), .TIMEOUT(TIMEOUT), .ZERO_REG(0)) u_dut_z0 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready_z),
    .ra(ra), .rb(rb), .rd(rd), .wb(wb), .alu_done(alu_done), .alu_start(alu_start_z),
    .sel_a(sel_a_z), .sel_b(sel_b_z), .en(en_z), .done(done_z), .err(err_z), .busy(busy_z)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every cycle, away from the active edge.
  int  exec_cnt  = 0;
  bit  prev_rst  = 1'b0;
  bit  prev_acc  = 1'b0;
  bit  prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_outs", {3'b0, instr_ready, alu_start, sel_a, sel_b, en, done, err, busy}, 32'h0);
      chk("rst_outs_z0", {3'b0, instr_ready_z, alu_start_z, sel_a_z, sel_b_z, en_z, done_z, err_z, busy_z}, 32'h0);
      q.delete();
      exec_cnt  = 0;
      prev_rst  = 1'b1;
      prev_acc  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_rst) chk("ready_after_rst", {31'b0, instr_ready}, 32'h1);
      prev_rst = 1'b0;
      chk("invariants", {28'b0, $onehot0(sel_a), $onehot0(sel_b), $onehot0(en),
                         !((en != 8'h00) && ((sel_a | sel_b) != 8'h00) || (en != 8'h00 && !done))},
          32'hF);
      if (prev_acc)  chk("accept_start", {30'b0, busy, alu_start}, 32'h3);
      if (prev_done) chk("ready_after_done", {31'b0, instr_ready}, 32'h1);
      if (busy && !done) begin
        exec_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_exec", 32'h1, 32'h0);
        end else begin
          chk("sel_a", {24'b0, sel_a}, {24'b0, q[0].sa});
          chk("sel_b", {24'b0, sel_b}, {24'b0, q[0].sb});
          chk("alu_start", {31'b0, alu_start}, {31'b0, exec_cnt == 1});
        end
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'h1, 32'h0);
        end else begin
          e = q.pop_front();
          chk("done_not_timeout", {31'b0, e.to}, 32'h0);
          chk("en", {24'b0, en}, {24'b0, e.en1});
          chk("en_z0", {24'b0, en_z}, {24'b0, e.en0});
          chk("exec_cycles", exec_cnt, e.k);
          chk("ready_in_write", {30'b0, instr_ready, done_z}, 32'h1);
        end
        exec_cnt = 0;
      end
      if (err) begin
        if (q.size() == 0) begin
          chk("unexpected_err", 32'h1, 32'h0);
        end else begin
          e = q.pop_front();
          chk("err_is_timeout", {31'b0, e.to}, 32'h1);
          chk("timeout_cycles", exec_cnt, TIMEOUT);
          chk("err_cycle_state", {22'b0, en, busy, instr_ready}, 32'h1);
        end
        exec_cnt = 0;
      end
      prev_acc  = instr_valid && instr_ready;
      prev_done = done;
    end
  end

  // Waits for ready with a bound, then lets the next edge accept.
  task automatic accept();
    int guard = 0;
    while (!instr_ready) begin
      if (guard++ > 40) begin
        chk("ready_timeout", 32'h1, 32'h0);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  // dly = EXEC cycle on which alu_done is raised; 0 means never (watchdog).
  task automatic run_op(input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                        input logic w, input int dly, input logic [7:0] sa,
                        input logic [7:0] sb, input logic [7:0] e1, input logic [7:0] e0,
                        input bit keep);
    exp_t e;
    int n;
    e.sa = sa; e.sb = sb; e.en1 = e1; e.en0 = e0;
    e.k  = (dly == 0) ? TIMEOUT : dly;
    e.to = (dly == 0);
    q.push_back(e);
    ra = a; rb = b; rd = d; wb = w;
    instr_valid = 1'b1;
    accept();
    if (!keep) instr_valid = 1'b0;
    n = e.k;
    for (int c = 1; c <= n; c++) begin
      alu_done = (c == dly);
      @(posedge clk); #1;
    end
    alu_done = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [2:0] a, b, d;
    logic       w;
    logic [7:0] one;
    int guard;

    rst = 1'b1; instr_valid = 1'b0; ra = '0; rb = '0; rd = '0; wb = 1'b0; alu_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // alu_done raised outside EXEC must be ignored.
    alu_done = 1'b1;
    @(posedge clk); #1;
    alu_done = 1'b0;

    run_op(3'd2, 3'd5, 3'd3, 1'b1, 2, 8'h04, 8'h20, 8'h08, 8'h08, 1'b0);
    run_op(3'd6, 3'd6, 3'd1, 1'b0, 1, 8'h40, 8'h40, 8'h00, 8'h00, 1'b0);
    run_op(3'd1, 3'd2, 3'd0, 1'b1, 1, 8'h02, 8'h04, 8'h00, 8'h01, 1'b0);

    // Watchdog expiry, then a new op accepted in the err cycle itself.
    run_op(3'd3, 3'd4, 3'd5, 1'b1, 0, 8'h08, 8'h10, 8'h00, 8'h00, 1'b0);
    run_op(3'd1, 3'd1, 3'd7, 1'b1, 1, 8'h02, 8'h02, 8'h80, 8'h80, 1'b0);

    // alu_done on the final watchdog cycle completes normally.
    run_op(3'd0, 3'd7, 3'd2, 1'b1, TIMEOUT, 8'h01, 8'h80, 8'h04, 8'h04, 1'b0);

    // Back-to-back with instr_valid held high.
    run_op(3'd5, 3'd3, 3'd4, 1'b1, 1, 8'h20, 8'h08, 8'h10, 8'h10, 1'b1);
    run_op(3'd2, 3'd2, 3'd7, 1'b1, 3, 8'h04, 8'h04, 8'h80, 8'h80, 1'b1);
    run_op(3'd0, 3'd1, 3'd0, 1'b1, 2, 8'h01, 8'h02, 8'h00, 8'h01, 1'b0);

    // Random operands and completion delays.
    for (int i = 0; i < 8; i++) begin
      a = 3'($urandom_range(0, 7));
      b = 3'($urandom_range(0, 7));
      d = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      one = 8'h01;
      run_op(a, b, d, w, $urandom_range(1, TIMEOUT), one << a, one << b,
             (w && d != 3'd0) ? (one << d) : 8'h00, w ? (one << d) : 8'h00, 1'b0);
    end

    // Reset in the middle of EXEC aborts the op silently.
    e.sa = 8'h10; e.sb = 8'h02; e.en1 = 8'h04; e.en0 = 8'h04; e.k = 3; e.to = 1'b0;
    q.push_back(e);
    ra = 3'd4; rb = 3'd1; rd = 3'd2; wb = 1'b1;
    instr_valid = 1'b1;
    accept();
    instr_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    alu_done = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    alu_done = 1'b0;
    repeat (4) begin @(posedge clk); #1; end

    run_op(3'd7, 3'd0, 3'd6, 1'b1, 3, 8'h80, 8'h01, 8'h40, 8'h40, 1'b0);

    guard = 0;
    while (q.size() != 0 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
